// File: rtl/axi4_bram_slave.sv
// AXI4 memory responder over an inferred dual-port block RAM.
// Independent write and read FSMs; the R path keeps a 2-entry skid behind the 1-cycle RAM read.
module axi4_bram_slave #(
    parameter int                    DATA_WIDTH = 64,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    ID_WIDTH   = 1,
    parameter int                    MEM_WORDS  = 8192,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    // write address
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [7:0]              awlen,
    input  logic [1:0]              awburst,
    input  logic                    awvalid,
    output logic                    awready,
    // write data
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    // write response
    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    // read address
    input  logic [ID_WIDTH-1:0]     arid,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [7:0]              arlen,
    input  logic [1:0]              arburst,
    input  logic                    arvalid,
    output logic                    arready,
    // read data
    output logic [ID_WIDTH-1:0]     rid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    rvalid,
    input  logic                    rready
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int SHIFT  = $clog2(STRB_W);
    localparam int RAM_AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(STRB_W - 1);
    localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(STRB_W);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A    = ADDR_WIDTH'(MEM_WORDS);

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] off;
        off = a - BASE_ADDR;
        return (a >= BASE_ADDR) && ((off >> SHIFT) < DEPTH_A);
    endfunction

    function automatic logic [RAM_AW-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] off;
        off = a - BASE_ADDR;
        return RAM_AW'(off >> SHIFT);
    endfunction

    // ------------------------------------------------------------------
    // Block RAM: byte-enabled write port, registered read port, read-first
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem_array [0:MEM_WORDS-1];
    logic [DATA_WIDTH-1:0] ram_q;
    logic [STRB_W-1:0]     ram_be;
    logic                  ram_we;
    logic [RAM_AW-1:0]     w_idx;
    logic [RAM_AW-1:0]     r_idx;

    for (genvar gi = 0; gi < STRB_W; gi++) begin : g_be
        assign ram_be[gi] = ram_we & wstrb[gi];
    end

    always_ff @(posedge clk_i) begin
        for (int b = 0; b < STRB_W; b++) begin
            if (ram_be[b]) begin
                mem_array[w_idx][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
        ram_q <= mem_array[r_idx];
    end

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    logic [1:0]            w_state_reg;
    logic                  awready_reg;
    logic                  wready_reg;
    logic                  bvalid_reg;
    logic [1:0]            bresp_reg;
    logic [ID_WIDTH-1:0]   bid_reg;
    logic [ADDR_WIDTH-1:0] aw_addr_reg;
    logic [7:0]            aw_len_reg;
    logic [1:0]            aw_burst_reg;
    logic [7:0]            w_cnt_reg;
    logic                  w_slverr_reg;
    logic                  w_decerr_reg;

    logic w_hs;
    logic w_last_beat;
    logic w_unsup;
    logic w_beat_slv;
    logic w_beat_dec;
    logic w_slv_acc;
    logic w_dec_acc;

    assign w_hs        = (w_state_reg == W_DATA) && wvalid && wready_reg;
    assign w_last_beat = (w_cnt_reg == aw_len_reg);
    assign w_unsup     = (aw_burst_reg != BURST_FIXED) && (aw_burst_reg != BURST_INCR);
    assign w_beat_slv  = w_unsup || (w_last_beat != wlast);
    assign w_beat_dec  = !w_unsup && !addr_ok(aw_addr_reg);
    assign w_slv_acc   = w_slverr_reg | w_beat_slv;
    assign w_dec_acc   = w_decerr_reg | w_beat_dec;

    assign ram_we = w_hs && !w_unsup && addr_ok(aw_addr_reg);
    assign w_idx  = addr_idx(aw_addr_reg);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            w_state_reg  <= W_IDLE;
            awready_reg  <= 1'b0;
            wready_reg   <= 1'b0;
            bvalid_reg   <= 1'b0;
            bresp_reg    <= RESP_OKAY;
            bid_reg      <= '0;
            aw_addr_reg  <= '0;
            aw_len_reg   <= '0;
            aw_burst_reg <= '0;
            w_cnt_reg    <= '0;
            w_slverr_reg <= 1'b0;
            w_decerr_reg <= 1'b0;
        end else begin
            case (w_state_reg)
                W_IDLE: begin
                    awready_reg <= 1'b1;
                    if (awready_reg && awvalid) begin
                        awready_reg  <= 1'b0;
                        wready_reg   <= 1'b1;
                        bid_reg      <= awid;
                        aw_addr_reg  <= awaddr & ~ALIGN_MASK;
                        aw_len_reg   <= awlen;
                        aw_burst_reg <= awburst;
                        w_cnt_reg    <= '0;
                        w_slverr_reg <= 1'b0;
                        w_decerr_reg <= 1'b0;
                        w_state_reg  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        if (aw_burst_reg == BURST_INCR) begin
                            aw_addr_reg <= aw_addr_reg + STEP;
                        end
                        w_cnt_reg    <= w_cnt_reg + 8'd1;
                        w_slverr_reg <= w_slv_acc;
                        w_decerr_reg <= w_dec_acc;
                        // Beat count alone closes the burst; wlast only grades the response
                        if (w_last_beat) begin
                            wready_reg  <= 1'b0;
                            bvalid_reg  <= 1'b1;
                            bresp_reg   <= w_dec_acc ? RESP_DECERR :
                                           w_slv_acc ? RESP_SLVERR : RESP_OKAY;
                            w_state_reg <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid_reg  <= 1'b0;
                        awready_reg <= 1'b1;
                        w_state_reg <= W_IDLE;
                    end
                end
                default: begin
                    w_state_reg <= W_IDLE;
                end
            endcase
        end
    end

    assign awready = awready_reg;
    assign wready  = wready_reg;
    assign bvalid  = bvalid_reg;
    assign bresp   = bresp_reg;
    assign bid     = bid_reg;

    // ------------------------------------------------------------------
    // Read channel: issue -> RAM stage (p_*) -> output register + skid
    // ------------------------------------------------------------------
    logic [0:0]            r_state_reg;
    logic                  arready_reg;
    logic [ID_WIDTH-1:0]   rid_reg;
    logic [ADDR_WIDTH-1:0] ar_addr_reg;
    logic [7:0]            ar_len_reg;
    logic [1:0]            ar_burst_reg;
    logic [7:0]            r_cnt_reg;
    logic                  r_done_reg;

    logic                  p_vld_reg;
    logic [1:0]            p_resp_reg;
    logic                  p_last_reg;
    logic                  p_zero_reg;

    logic                  rvalid_reg;
    logic [DATA_WIDTH-1:0] rdata_reg;
    logic [1:0]            rresp_reg;
    logic                  rlast_reg;
    logic                  skid_vld_reg;
    logic [DATA_WIDTH-1:0] skid_data_reg;
    logic [1:0]            skid_resp_reg;
    logic                  skid_last_reg;

    logic                  ar_hs;
    logic                  r_consume;
    logic [1:0]            r_occ;
    logic                  r_can_issue;
    logic                  r_issue_data;
    logic                  r_issue;
    logic [ADDR_WIDTH-1:0] iss_addr;
    logic [1:0]            iss_burst;
    logic                  iss_last;
    logic                  iss_unsup;
    logic                  iss_ok;
    logic [1:0]            iss_resp;
    logic [ADDR_WIDTH-1:0] iss_next_addr;
    logic [DATA_WIDTH-1:0] p_data;

    assign ar_hs     = (r_state_reg == R_IDLE) && arready_reg && arvalid;
    assign r_consume = rvalid_reg && rready;

    // A beat may be issued only if everything in flight still fits in output + skid
    assign r_occ        = 2'(rvalid_reg) + 2'(skid_vld_reg) + 2'(p_vld_reg);
    assign r_can_issue  = (r_occ - 2'(r_consume)) <= 2'd1;
    assign r_issue_data = (r_state_reg == R_DATA) && !r_done_reg && r_can_issue;
    assign r_issue      = ar_hs || r_issue_data;

    // Beat 0 is issued straight from the AR channel to hit rvalid two cycles later
    assign iss_addr      = ar_hs ? (araddr & ~ALIGN_MASK) : ar_addr_reg;
    assign iss_burst     = ar_hs ? arburst : ar_burst_reg;
    assign iss_last      = ar_hs ? (arlen == 8'd0) : (r_cnt_reg == ar_len_reg);
    assign iss_unsup     = (iss_burst != BURST_FIXED) && (iss_burst != BURST_INCR);
    assign iss_ok        = addr_ok(iss_addr);
    assign iss_resp      = iss_unsup ? RESP_SLVERR : (!iss_ok ? RESP_DECERR : RESP_OKAY);
    assign iss_next_addr = (iss_burst == BURST_INCR) ? iss_addr + STEP : iss_addr;
    assign r_idx         = addr_idx(iss_addr);
    assign p_data        = p_zero_reg ? '0 : ram_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state_reg  <= R_IDLE;
            arready_reg  <= 1'b0;
            rid_reg      <= '0;
            ar_addr_reg  <= '0;
            ar_len_reg   <= '0;
            ar_burst_reg <= '0;
            r_cnt_reg    <= '0;
            r_done_reg   <= 1'b0;
            p_vld_reg    <= 1'b0;
            p_resp_reg   <= RESP_OKAY;
            p_last_reg   <= 1'b0;
            p_zero_reg   <= 1'b0;
        end else begin
            p_vld_reg  <= r_issue;
            p_resp_reg <= iss_resp;
            p_last_reg <= iss_last;
            p_zero_reg <= iss_unsup || !iss_ok;
            case (r_state_reg)
                R_IDLE: begin
                    arready_reg <= 1'b1;
                    if (ar_hs) begin
                        arready_reg  <= 1'b0;
                        rid_reg      <= arid;
                        ar_len_reg   <= arlen;
                        ar_burst_reg <= arburst;
                        ar_addr_reg  <= iss_next_addr;
                        r_cnt_reg    <= 8'd1;
                        r_done_reg   <= (arlen == 8'd0);
                        r_state_reg  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (r_issue_data) begin
                        ar_addr_reg <= iss_next_addr;
                        r_cnt_reg   <= r_cnt_reg + 8'd1;
                        if (iss_last) begin
                            r_done_reg <= 1'b1;
                        end
                    end
                    if (r_consume && rlast_reg) begin
                        arready_reg <= 1'b1;
                        r_state_reg <= R_IDLE;
                    end
                end
                default: begin
                    r_state_reg <= R_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rvalid_reg    <= 1'b0;
            rdata_reg     <= '0;
            rresp_reg     <= RESP_OKAY;
            rlast_reg     <= 1'b0;
            skid_vld_reg  <= 1'b0;
            skid_data_reg <= '0;
            skid_resp_reg <= RESP_OKAY;
            skid_last_reg <= 1'b0;
        end else if (!rvalid_reg || r_consume) begin
            // Output slot frees up: the skid entry is older than the RAM stage
            if (skid_vld_reg) begin
                rvalid_reg   <= 1'b1;
                rdata_reg    <= skid_data_reg;
                rresp_reg    <= skid_resp_reg;
                rlast_reg    <= skid_last_reg;
                skid_vld_reg <= p_vld_reg;
                if (p_vld_reg) begin
                    skid_data_reg <= p_data;
                    skid_resp_reg <= p_resp_reg;
                    skid_last_reg <= p_last_reg;
                end
            end else if (p_vld_reg) begin
                rvalid_reg <= 1'b1;
                rdata_reg  <= p_data;
                rresp_reg  <= p_resp_reg;
                rlast_reg  <= p_last_reg;
            end else begin
                rvalid_reg <= 1'b0;
            end
        end else if (p_vld_reg) begin
            skid_vld_reg  <= 1'b1;
            skid_data_reg <= p_data;
            skid_resp_reg <= p_resp_reg;
            skid_last_reg <= p_last_reg;
        end
    end

    assign arready = arready_reg;
    assign rid     = rid_reg;
    assign rvalid  = rvalid_reg;
    assign rdata   = rdata_reg;
    assign rresp   = rresp_reg;
    assign rlast   = rlast_reg;

endmodule

// File: tb/tb_axi4_bram_slave.sv
// Directed bench for axi4_bram_slave: vector table of bursts plus hand-written
// sequences for latency, backpressure, same-cycle read/write and mid-burst reset.
module tb_axi4_bram_slave;

    localparam logic [1:0] FIXED  = 2'b00;
    localparam logic [1:0] INCR   = 2'b01;
    localparam logic [1:0] WRAP   = 2'b10;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;
    localparam int         TMO    = 50;
    localparam int         NV     = 17;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [0:0]  awid, bid, arid, rid;
    logic [31:0] awaddr, araddr;
    logic [7:0]  awlen, arlen, wstrb;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic [63:0] wdata, rdata;

    always #5 clk = ~clk;

    axi4_bram_slave dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    typedef struct {
        logic        is_wr;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [1:0]  burst;
        logic        id;
        logic [7:0]  strb;
        logic [63:0] data0;  // write data of beat 0, or expected read data of beat 0
        logic [1:0]  resp;
        logic        step;   // expected read data increments per beat
    } vec_t;

    vec_t        tbl [NV];
    int          checks = 0;
    int          errors = 0;
    logic [63:0] rd_data_q [$];
    logic [1:0]  rd_resp_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tmo(input string name);
        checks++;
        errors++;
        $display("FAIL %s timed out", name);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic id, input logic [63:0] data0, input logic [7:0] strb,
                            input int wlast_at, output logic [1:0] resp);
        int n;
        resp = 2'b00;
        @(posedge clk); #1;
        awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!awready && n < TMO);
        if (!awready) begin tmo("aw_wait"); awvalid = 1'b0; return; end
        @(posedge clk); #1;
        awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            wdata = data0 + 64'(i); wstrb = strb; wlast = (i == wlast_at); wvalid = 1'b1;
            n = 0;
            do begin @(negedge clk); n++; end while (!wready && n < TMO);
            if (!wready) begin tmo("w_wait"); wvalid = 1'b0; return; end
            @(posedge clk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
        @(negedge clk);
        chk("b_valid_latency", 64'(bvalid), 64'd1);
        chk("b_id", 64'(bid), 64'(id));
        resp = bresp;
        @(posedge clk); #1;
        @(negedge clk);
        chk("b_valid_drop", 64'(bvalid), 64'd0);
        $display("WR addr=%h len=%0d burst=%0d bresp=%0d", addr, len, burst, resp);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input logic id, input logic bp);
        int          n, got, cyc;
        logic        first, held, h_last;
        logic [63:0] h_data;
        logic [1:0]  h_resp;
        rd_data_q.delete(); rd_resp_q.delete();
        @(posedge clk); #1;
        arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
        rready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!arready && n < TMO);
        if (!arready) begin tmo("ar_wait"); arvalid = 1'b0; return; end
        @(posedge clk); #1;
        arvalid = 1'b0;
        @(negedge clk);
        chk("r_not_early", 64'(rvalid), 64'd0);
        @(posedge clk); #1;
        if (bp) rready = 1'($urandom_range(0, 1));
        got = 0; cyc = 0; first = 1'b1; held = 1'b0;
        h_data = '0; h_resp = '0; h_last = 1'b0;
        while (got <= int'(len) && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (first) begin
                chk("r_first_latency", 64'(rvalid), 64'd1);
                first = 1'b0;
            end
            if (held) begin
                chk("r_hold_valid", 64'(rvalid), 64'd1);
                chk("r_hold_data", rdata, h_data);
                chk("r_hold_resp", 64'(rresp), 64'(h_resp));
                chk("r_hold_last", 64'(rlast), 64'(h_last));
                held = 1'b0;
            end
            if (rvalid && rready) begin
                rd_data_q.push_back(rdata);
                rd_resp_q.push_back(rresp);
                chk("r_last", 64'(rlast), 64'(got == int'(len)));
                chk("r_id", 64'(rid), 64'(id));
                got++;
            end else if (rvalid) begin
                held = 1'b1; h_data = rdata; h_resp = rresp; h_last = rlast;
            end
            @(posedge clk); #1;
            if (bp) rready = 1'($urandom_range(0, 1));
        end
        if (got <= int'(len)) tmo("r_beats");
        rready = 1'b1;
        @(negedge clk);
        chk("r_idle_after_last", 64'(rvalid), 64'd0);
        chk("ar_ready_after_last", 64'(arready), 64'd1);
        $display("RD addr=%h len=%0d burst=%0d beats=%0d", addr, len, burst, got);
    endtask

    task automatic chk_beat(input string name, input int i, input logic [63:0] d, input logic [1:0] r);
        if (i < rd_data_q.size()) begin
            chk($sformatf("%s_data%0d", name, i), rd_data_q[i], d);
            chk($sformatf("%s_resp%0d", name, i), 64'(rd_resp_q[i]), 64'(r));
        end else begin
            tmo($sformatf("%s_beat%0d_missing", name, i));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [1:0] resp;
        int         n;

        tbl[0]  = '{1'b1, 32'h0000_0000, 8'd0, INCR,  1'b0, 8'hFF, 64'hA5A5_A5A5_5A5A_5A5A, OKAY,   1'b0};
        tbl[1]  = '{1'b1, 32'h0000_0100, 8'd3, INCR,  1'b1, 8'hFF, 64'h0,                   OKAY,   1'b0};
        tbl[2]  = '{1'b0, 32'h0000_0100, 8'd3, INCR,  1'b1, 8'h00, 64'h0,                   OKAY,   1'b1};
        tbl[3]  = '{1'b1, 32'h0000_0200, 8'd0, INCR,  1'b0, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, OKAY,   1'b0};
        tbl[4]  = '{1'b1, 32'h0000_0200, 8'd0, INCR,  1'b1, 8'h0F, 64'h0,                   OKAY,   1'b0};
        tbl[5]  = '{1'b0, 32'h0000_0200, 8'd0, INCR,  1'b0, 8'h00, 64'hFFFF_FFFF_0000_0000, OKAY,   1'b0};
        tbl[6]  = '{1'b1, 32'h0001_0000, 8'd0, INCR,  1'b1, 8'hFF, 64'h1234,                DECERR, 1'b0};
        tbl[7]  = '{1'b0, 32'h0000_0000, 8'd0, INCR,  1'b0, 8'h00, 64'hA5A5_A5A5_5A5A_5A5A, OKAY,   1'b0};
        tbl[8]  = '{1'b0, 32'h0001_0000, 8'd0, INCR,  1'b1, 8'h00, 64'h0,                   DECERR, 1'b0};
        tbl[9]  = '{1'b1, 32'h0000_0300, 8'd2, FIXED, 1'b0, 8'hFF, 64'h10,                  OKAY,   1'b0};
        tbl[10] = '{1'b0, 32'h0000_0300, 8'd2, FIXED, 1'b1, 8'h00, 64'h12,                  OKAY,   1'b0};
        tbl[11] = '{1'b1, 32'h0000_0300, 8'd1, WRAP,  1'b1, 8'hFF, 64'h99,                  SLVERR, 1'b0};
        tbl[12] = '{1'b0, 32'h0000_0300, 8'd0, INCR,  1'b0, 8'h00, 64'h12,                  OKAY,   1'b0};
        tbl[13] = '{1'b0, 32'h0000_0300, 8'd1, WRAP,  1'b1, 8'h00, 64'h0,                   SLVERR, 1'b0};
        tbl[14] = '{1'b1, 32'h0000_0405, 8'd0, INCR,  1'b0, 8'hFF, 64'hDEAD,                OKAY,   1'b0};
        tbl[15] = '{1'b0, 32'h0000_0400, 8'd0, INCR,  1'b1, 8'h00, 64'hDEAD,                OKAY,   1'b0};
        tbl[16] = '{1'b0, 32'h0000_0101, 8'd1, INCR,  1'b0, 8'h00, 64'h0,                   OKAY,   1'b1};

        rst_n = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b1;
        arid = '0; araddr = '0; arlen = '0; arburst = '0; arvalid = 1'b0; rready = 1'b1;

        // Reset values and ready timing after release
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("rst_awready", 64'(awready), 64'd0);
        chk("rst_arready", 64'(arready), 64'd0);
        chk("rst_wready", 64'(wready), 64'd0);
        chk("rst_bvalid", 64'(bvalid), 64'd0);
        chk("rst_rvalid", 64'(rvalid), 64'd0);
        chk("rst_rlast", 64'(rlast), 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        chk("rst_bresp", 64'(bresp), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_awready_c0", 64'(awready), 64'd0);
        @(negedge clk);
        chk("rel_awready_c1", 64'(awready), 64'd1);
        chk("rel_arready_c1", 64'(arready), 64'd1);

        for (int v = 0; v < NV; v++) begin
            if (tbl[v].is_wr) begin
                do_write(tbl[v].addr, tbl[v].len, tbl[v].burst, tbl[v].id, tbl[v].data0,
                         tbl[v].strb, int'(tbl[v].len), resp);
                chk($sformatf("vec%0d_bresp", v), 64'(resp), 64'(tbl[v].resp));
            end else begin
                do_read(tbl[v].addr, tbl[v].len, tbl[v].burst, tbl[v].id, 1'b0);
                for (int i = 0; i <= int'(tbl[v].len); i++) begin
                    chk_beat($sformatf("vec%0d", v), i,
                             tbl[v].data0 + (tbl[v].step ? 64'(i) : 64'd0), tbl[v].resp);
                end
            end
        end

        // Burst crossing the top of memory: in-range beat kept, out-of-range beat dropped
        do_write(32'h0000_FFF8, 8'd1, INCR, 1'b0, 64'h77, 8'hFF, 1, resp);
        chk("edge_wr_bresp", 64'(resp), 64'(DECERR));
        do_read(32'h0000_FFF8, 8'd1, INCR, 1'b0, 1'b0);
        chk_beat("edge_rd", 0, 64'h77, OKAY);
        chk_beat("edge_rd", 1, 64'h0, DECERR);
        do_read(32'h0000_0000, 8'd0, INCR, 1'b1, 1'b0);
        chk_beat("edge_alias", 0, 64'hA5A5_A5A5_5A5A_5A5A, OKAY);

        // Early and missing wlast
        do_write(32'h0000_0600, 8'd3, INCR, 1'b0, 64'h50, 8'hFF, 1, resp);
        chk("early_wlast_bresp", 64'(resp), 64'(SLVERR));
        do_read(32'h0000_0600, 8'd3, INCR, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) chk_beat("early_wlast_rd", i, 64'h50 + 64'(i), OKAY);
        do_write(32'h0000_0700, 8'd1, INCR, 1'b1, 64'h60, 8'hFF, 255, resp);
        chk("no_wlast_bresp", 64'(resp), 64'(SLVERR));

        // Long read under random backpressure
        do_write(32'h0000_0800, 8'd15, INCR, 1'b1, 64'h1000, 8'hFF, 15, resp);
        chk("bp_wr_bresp", 64'(resp), 64'(OKAY));
        do_read(32'h0000_0800, 8'd15, INCR, 1'b1, 1'b1);
        chk("bp_nbeats", 64'(rd_data_q.size()), 64'd16);
        for (int i = 0; i < 16; i++) chk_beat("bp_rd", i, 64'h1000 + 64'(i), OKAY);

        // Same-cycle write and read of one word: read returns the old value
        do_write(32'h0000_0500, 8'd0, INCR, 1'b0, 64'h1111, 8'hFF, 0, resp);
        @(posedge clk); #1;
        awid = 1'b0; awaddr = 32'h500; awlen = 8'd0; awburst = INCR; awvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!awready && n < TMO);
        if (!awready) tmo("rw_aw_wait");
        @(posedge clk); #1;
        awvalid = 1'b0;
        wdata = 64'h2222; wstrb = 8'hFF; wlast = 1'b1; wvalid = 1'b1;
        arid = 1'b1; araddr = 32'h500; arlen = 8'd0; arburst = INCR; arvalid = 1'b1; rready = 1'b1;
        @(negedge clk);
        chk("rw_same_wready", 64'(wready), 64'd1);
        chk("rw_same_arready", 64'(arready), 64'd1);
        @(posedge clk); #1;
        wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!rvalid && n < TMO);
        if (!rvalid) tmo("rw_r_wait");
        else chk("rw_read_first_old", rdata, 64'h1111);
        repeat (3) @(posedge clk);
        $display("RW addr=00000500 same-cycle write and read done");
        do_read(32'h0000_0500, 8'd0, INCR, 1'b0, 1'b0);
        chk_beat("rw_read_new", 0, 64'h2222, OKAY);

        // Reset in the middle of a stalled read burst
        @(posedge clk); #1;
        arid = 1'b0; araddr = 32'h800; arlen = 8'd15; arburst = INCR; arvalid = 1'b1; rready = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!arready && n < TMO);
        if (!arready) tmo("mid_ar_wait");
        @(posedge clk); #1;
        arvalid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("mid_rvalid_before", 64'(rvalid), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rvalid_at_reset", 64'(rvalid), 64'd0);
        chk("mid_arready_at_reset", 64'(arready), 64'd0);
        repeat (3) @(posedge clk); #1;
        rst_n = 1'b1;
        rready = 1'b1;
        @(negedge clk);
        chk("mid_arready_c0", 64'(arready), 64'd0);
        @(negedge clk);
        chk("mid_arready_c1", 64'(arready), 64'd1);
        chk("mid_rvalid_after", 64'(rvalid), 64'd0);
        $display("RST mid-burst reset done");
        do_read(32'h0000_0800, 8'd1, INCR, 1'b1, 1'b0);
        chk_beat("post_rst_rd", 0, 64'h1000, OKAY);
        chk_beat("post_rst_rd", 1, 64'h1001, OKAY);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
